// File: rtl/nbdcache_sram_pkg.sv
// Shared helpers for the nbdcache SRAM: derived widths and byte-lane mapping.
package nbdcache_sram_pkg;

  function automatic int unsigned addr_width(int unsigned num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

  function automatic int unsigned be_width(int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

  // Byte-enable lane that owns a given data bit; drives per-bit write mask generation.
  function automatic int unsigned lane_of(int unsigned bit_idx);
    return bit_idx / 8;
  endfunction

endpackage

// File: rtl/nbdcache_sram_be_merge.sv
// Byte-enable merge of a stored word with write data; the top lane may be narrower than 8 bits.
module nbdcache_sram_be_merge
  import nbdcache_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic [DATA_WIDTH-1:0] new_o
);

  logic [DATA_WIDTH-1:0] mask;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign mask[i] = be_i[lane_of(i)];
  end

  assign new_o = (old_i & ~mask) | (wdata_i & mask);

endmodule

// File: rtl/nbdcache_sram.sv
// Single-port byte-enabled SRAM, 1-cycle read latency, write-first output register.
// Define NBDCACHE_SRAM_ZERO_INIT_EN to clear the array while reset is asserted.
module nbdcache_sram
  import nbdcache_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  localparam int unsigned ADDR_WIDTH = addr_width(NUM_WORDS),
  localparam int unsigned BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  in_range;
  logic                  wr_en;

  // Only matters for non-power-of-two depths; otherwise constant true.
  assign in_range = 32'(addr_i) < NUM_WORDS;
  assign old_word = in_range ? mem[addr_i] : '0;
  // Gating with rst_ni drops a write that coincides with an active reset.
  assign wr_en    = req_i & we_i & in_range & rst_ni;

  nbdcache_sram_be_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_be_merge (
    .old_i  (old_word),
    .wdata_i(wdata_i),
    .be_i   (be_i),
    .new_o  (new_word)
  );

`ifdef NBDCACHE_SRAM_ZERO_INIT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr_i] <= new_word;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[addr_i] <= new_word;
    end
  end
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (req_i) begin
      rdata_d = !in_range ? '0 : (we_i ? new_word : old_word);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_nbdcache_sram.sv
// Directed bench for nbdcache_sram: a 64x256 instance and a 44-bit, 20-word instance.
module tb_nbdcache_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        req64, we64;
  logic [7:0]  addr64;
  logic [63:0] wdata64, rdata64;
  logic [7:0]  be64;

  logic        req44, we44;
  logic [4:0]  addr44;
  logic [43:0] wdata44, rdata44;
  logic [5:0]  be44;

  nbdcache_sram #(.DATA_WIDTH(64), .NUM_WORDS(256)) u_dut64 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req64),
    .we_i   (we64),
    .addr_i (addr64),
    .wdata_i(wdata64),
    .be_i   (be64),
    .rdata_o(rdata64)
  );

  nbdcache_sram #(.DATA_WIDTH(44), .NUM_WORDS(20)) u_dut44 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req44),
    .we_i   (we44),
    .addr_i (addr44),
    .wdata_i(wdata44),
    .be_i   (be44),
    .rdata_o(rdata44)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req64 = 1'b0; we64 = 1'b0;
    req44 = 1'b0; we44 = 1'b0;
  endtask

  task automatic wr64(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    req64 = 1'b1; we64 = 1'b1; addr64 = a; wdata64 = d; be64 = be;
    cycle();
    req64 = 1'b0; we64 = 1'b0;
  endtask

  task automatic rd64(input logic [7:0] a);
    req64 = 1'b1; we64 = 1'b0; addr64 = a; be64 = 8'h00;
    cycle();
    req64 = 1'b0;
  endtask

  task automatic wr44(input logic [4:0] a, input logic [43:0] d, input logic [5:0] be);
    req44 = 1'b1; we44 = 1'b1; addr44 = a; wdata44 = d; be44 = be;
    cycle();
    req44 = 1'b0; we44 = 1'b0;
  endtask

  task automatic rd44(input logic [4:0] a);
    req44 = 1'b1; we44 = 1'b0; addr44 = a; be44 = 6'h00;
    cycle();
    req44 = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    addr64 = '0; wdata64 = '0; be64 = '0;
    addr44 = '0; wdata44 = '0; be44 = '0;
    rst_n = 1'b0;
    repeat (3) cycle();
    vectors++;
    if (rdata64 !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_rdata64: got %h want %h", rdata64, 64'h0);
    end
    vectors++;
    if (rdata44 !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_rdata44: got %h want %h", rdata44, 44'h0);
    end
    rst_n = 1'b1;
    cycle();
`ifdef NBDCACHE_SRAM_ZERO_INIT_EN
    rd64(8'd5);
    vectors++;
    if (rdata64 !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_zero_init_addr5: got %h want %h", rdata64, 64'h0);
    end
`endif
  endtask

  task automatic test_full_write_read();
    wr64(8'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    rd64(8'h10);
    vectors++;
    if (rdata64 !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL full_write_read: got %h want %h", rdata64, 64'hDEADBEEF_CAFEF00D);
    end
  endtask

  task automatic test_byte_mask();
    wr64(8'h10, 64'h11223344_55667788, 8'h0F);
    vectors++;
    if (rdata64 !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL byte_mask_write_first: got %h want %h", rdata64, 64'hDEADBEEF_55667788);
    end
    rd64(8'h10);
    vectors++;
    if (rdata64 !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL byte_mask_read: got %h want %h", rdata64, 64'hDEADBEEF_55667788);
    end
    wr64(8'h10, 64'h0, 8'h00);
    vectors++;
    if (rdata64 !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL be_zero_write: got %h want %h", rdata64, 64'hDEADBEEF_55667788);
    end
    rd64(8'h10);
    vectors++;
    if (rdata64 !== 64'hDEADBEEF_55667788) begin
      miscompares++;
      $display("FAIL be_zero_read: got %h want %h", rdata64, 64'hDEADBEEF_55667788);
    end
    wr64(8'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h81);
    vectors++;
    if (rdata64 !== 64'hFFADBEEF_556677FF) begin
      miscompares++;
      $display("FAIL byte_mask_ends: got %h want %h", rdata64, 64'hFFADBEEF_556677FF);
    end
  endtask

  task automatic test_partial_lane();
    wr44(5'd2, 44'hFFF_FFFF_FFFF, 6'h3F);
    wr44(5'd2, 44'h0, 6'h20);
    rd44(5'd2);
    vectors++;
    if (rdata44 !== 44'h0FF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL partial_top_lane: got %h want %h", rdata44, 44'h0FF_FFFF_FFFF);
    end
    wr44(5'd2, 44'hABC_0000_0000, 6'h10);
    vectors++;
    if (rdata44 !== 44'h0BC_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL partial_lane4: got %h want %h", rdata44, 44'h0BC_FFFF_FFFF);
    end
  endtask

  task automatic test_write_first_hold();
    wr64(8'd3, 64'hA5, 8'hFF);
    vectors++;
    if (rdata64 !== 64'hA5) begin
      miscompares++;
      $display("FAIL write_first: got %h want %h", rdata64, 64'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      addr64 = 8'(i * 37 + 1);
      wdata64 = {32'h5A5A5A5A, 32'(i)} ^ 64'hFFFF_0000_FFFF_0000;
      cycle();
      vectors++;
      if (rdata64 !== 64'hA5) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: got %h want %h", i, rdata64, 64'hA5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp [3];
    exp[0] = 64'h0101_0101_1111_1111;
    exp[1] = 64'h0202_0202_2222_2222;
    exp[2] = 64'h0303_0303_3333_3333;
    for (int i = 0; i < 3; i++) begin
      req64 = 1'b1; we64 = 1'b1; addr64 = 8'(i + 1); wdata64 = exp[i]; be64 = 8'hFF;
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      req64 = 1'b1; we64 = 1'b0; addr64 = 8'(i + 1);
      cycle();
      vectors++;
      if (rdata64 !== exp[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i + 1, rdata64, exp[i]);
      end
    end
    req64 = 1'b0;
  endtask

  task automatic test_out_of_range();
    wr44(5'd19, 44'h123_4567_89AB, 6'h3F);
    rd44(5'd19);
    vectors++;
    if (rdata44 !== 44'h123_4567_89AB) begin
      miscompares++;
      $display("FAIL last_word: got %h want %h", rdata44, 44'h123_4567_89AB);
    end
    wr44(5'd25, 44'hFED_CBA9_8765, 6'h3F);
    vectors++;
    if (rdata44 !== 44'h0) begin
      miscompares++;
      $display("FAIL oor_write_rdata: got %h want %h", rdata44, 44'h0);
    end
    rd44(5'd19);
    rd44(5'd25);
    vectors++;
    if (rdata44 !== 44'h0) begin
      miscompares++;
      $display("FAIL oor_read: got %h want %h", rdata44, 44'h0);
    end
    rd44(5'd19);
    vectors++;
    if (rdata44 !== 44'h123_4567_89AB) begin
      miscompares++;
      $display("FAIL oor_no_corrupt: got %h want %h", rdata44, 44'h123_4567_89AB);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] exp;
    wr64(8'd7, 64'h7777_0000_1234_5678, 8'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rdata64 !== 64'h0) begin
      miscompares++;
      $display("FAIL async_reset_rdata: got %h want %h", rdata64, 64'h0);
    end
    req64 = 1'b1; we64 = 1'b1; addr64 = 8'd7; wdata64 = 64'hBAD0_BAD0_BAD0_BAD0; be64 = 8'hFF;
    cycle();
    req64 = 1'b0; we64 = 1'b0;
    rst_n = 1'b1;
    cycle();
    rd64(8'd7);
`ifdef NBDCACHE_SRAM_ZERO_INIT_EN
    exp = 64'h0;
`else
    exp = 64'h7777_0000_1234_5678;
`endif
    vectors++;
    if (rdata64 !== exp) begin
      miscompares++;
      $display("FAIL reset_drops_write: got %h want %h", rdata64, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_mask();
    test_partial_lane();
    test_write_first_hold();
    test_back_to_back();
    test_out_of_range();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nbdcache_sram.md
# nbdcache_sram

Single-port, byte-enabled synchronous SRAM model used as the storage primitive of the non-blocking L1 data cache. Each set-associative way instantiates one for cache-line data and one for tags. A shared instance holds the byte-aligned valid/dirty bits. It has one-cycle read latency and per-byte write masking. A single request port is driven by the tag-compare/arbiter stage.

## Interface
Parameters:
- DATA_WIDTH, default 64: word width in bits, any value ≥ 1; need not be a multiple of 8.
- NUM_WORDS, default 1024: number of words, ≥ 1.
- Derived (localparams, not overridable):
  - ADDR_WIDTH = max(1, $clog2(NUM_WORDS)).
  - BE_WIDTH = (DATA_WIDTH+7)/8.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  access request for this cycle.
- we_i  in  1  1 = write, 0 = read; ignored when req_i=0.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  BE_WIDTH  byte enables; bit k covers wdata bits [8k+7:8k], clipped to DATA_WIDTH-1 for the top lane.
- rdata_o  out  DATA_WIDTH  registered read data.

## Operation
- Read (req_i=1, we_i=0): at the clock edge, the output register loads mem[addr_i]. be_i is ignored.
- Write (req_i=1, we_i=1): at the clock edge, only the bit lanes with be_i[k]=1 are updated from wdata_i; all other lanes keep their old value.
  - The output register loads the post-write word, i.e. write-first behaviour.
  - be_i=0 is legal: memory is unchanged and the output register loads the unchanged word.
- Idle (req_i=0): memory and rdata_o are held.
- Out-of-range address (addr_i ≥ NUM_WORDS, non-power-of-two sizes): writes are dropped and the output register loads 0.
- The partial top byte lane is handled with no padding bits stored. Example: DATA_WIDTH=44 gives BE_WIDTH=6, and lane 5 covers bits [43:40].
- Reset: rdata_o = 0. Array contents follow the Configuration section.

## Timing
- Read latency is 1 cycle. Request in cycle N gives valid rdata_o from just after edge N+1, and it holds until the next req_i.
- There is no grant or stall; every req_i is accepted in its cycle. Back-to-back accesses are allowed every cycle.
- Accessing the same address in consecutive cycles (write then read) returns the written data.
- Reset mid-operation: asserting rst_ni forces rdata_o to 0 immediately, independent of the clock. An in-flight write at the edge where reset is active is discarded. The first access after reset release is serviced normally.

## Configuration
- Macro NBDCACHE_SRAM_ZERO_INIT_EN.
- Defined: while rst_ni=0, every array word is cleared to 0. Cache valid/dirty bits therefore read 0 after reset.
- Undefined: the array is not reset. Contents after power-up are unspecified (X in simulation). Only rdata_o is reset.
- rdata_o reset behaviour is the same in both builds.

## Structure
- A shared package nbdcache_sram_pkg holds:
  - the addr_width(num_words) function;
  - the be_width(data_width) function;
  - the lane bit-mask generation function used for merging.
- One sub-module, nbdcache_sram_be_merge: combinational merge of old word, wdata and be into the new word. It handles the partial top lane.
- The top level contains only the array, the write port and the output register.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles, then release.
  - rdata_o=0.
  - With ZERO_INIT_EN, a read of address 5 returns 0.
- Full write/read: DATA_WIDTH=64, NUM_WORDS=256. Write 0xDEADBEEF_CAFEF00D to address 0x10 with be=0xFF, then read 0x10 → 0xDEADBEEF_CAFEF00D one cycle after the read.
- Byte mask: on the word above, write 0x11223344_55667788 with be=0x0F → read returns 0xDEADBEEF_55667788. be=0x00 leaves the word unchanged.
- Partial lane: DATA_WIDTH=44. Write all-ones with be=0x3F, then write 0 with be=0x20 → read returns 0x0FF_FFFF_FFFF (bits 43:40 cleared).
- Write-first and hold:
  - Writing 0xA5 to address 3 gives rdata_o=0xA5 after the write edge.
  - It stays 0xA5 over 4 idle cycles with req_i=0 while addr_i and wdata_i toggle.
- Back-to-back: reads of addresses 1, 2, 3 in consecutive cycles return their stored values, each one cycle later, with no gaps.
